// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types.
// Holds stage payload bundles and the buffer-slot helpers.
package cpu_types_pkg;

    typedef logic [1:0] pipe_occ_t;

    typedef enum logic [1:0] {
        SLOT_HOLD,
        SLOT_LOAD_IN,
        SLOT_LOAD_SKID,
        SLOT_CLEAR
    } slot_op_e;

    typedef struct packed {
        logic [31:0] wdat;
        logic [4:0]  wsel;
        logic        wen;
        logic        halt;
    } mem_wb_t;

    function automatic pipe_occ_t occ_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One {valid, halt, data} pipeline register.
// Clear wins over load and always leaves a zero NOP bubble.
module pipe_slot #(
    parameter int WIDTH = 128
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic             halt_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic             halt_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic             halt_q, halt_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next state: clear to a bubble, load a new beat, or hold.
    always_comb begin
        valid_d = valid_q;
        halt_d  = halt_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            halt_d  = 1'b0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            halt_d  = halt_i;
            data_d  = data_i;
        end
    end

    // Slot register, emptied immediately by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            halt_q  <= halt_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign halt_o  = halt_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage buffer with valid/ready, flush and sticky halt.
// SKID=1 adds a second entry so in_ready depends only on local state.
module pipe_stage_buf
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter bit SKID  = 1'b1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_halt,
    output pipe_occ_t        occupancy,
    output logic             halted
);

    logic             main_valid, main_halt;
    logic [WIDTH-1:0] main_data;
    logic             skid_valid, skid_halt;
    logic [WIDTH-1:0] skid_data;
    logic             push, pop;
    logic             halted_q, halted_d;
    slot_op_e         main_op;
    logic             main_halt_in;
    logic [WIDTH-1:0] main_data_in;

    assign push = in_valid && in_ready;
    assign pop  = main_valid && out_ready;

    // Head entry: refill from skid first, else from the input.
    always_comb begin
        main_op = SLOT_HOLD;
        if (flush) begin
            main_op = SLOT_CLEAR;
        end else if (pop && skid_valid) begin
            main_op = SLOT_LOAD_SKID;
        end else if (push && (!main_valid || pop)) begin
            main_op = SLOT_LOAD_IN;
        end else if (pop) begin
            main_op = SLOT_CLEAR;
        end
    end

    assign main_data_in = (main_op == SLOT_LOAD_SKID) ? skid_data : in_data;
    assign main_halt_in = (main_op == SLOT_LOAD_SKID) ? skid_halt : in_halt;

    pipe_slot #(.WIDTH(WIDTH)) u_main (
        .CLK     (CLK),
        .nRST    (nRST),
        .load_i  ((main_op == SLOT_LOAD_IN) || (main_op == SLOT_LOAD_SKID)),
        .clear_i (main_op == SLOT_CLEAR),
        .halt_i  (main_halt_in),
        .data_i  (main_data_in),
        .valid_o (main_valid),
        .halt_o  (main_halt),
        .data_o  (main_data)
    );

    generate
        if (SKID) begin : g_skid
            slot_op_e skid_op;

            // Skid entry: catch a beat the head cannot take this cycle.
            always_comb begin
                skid_op = SLOT_HOLD;
                if (flush) begin
                    skid_op = SLOT_CLEAR;
                end else if (push && main_valid && (!pop || skid_valid)) begin
                    skid_op = SLOT_LOAD_IN;
                end else if (pop && skid_valid) begin
                    skid_op = SLOT_CLEAR;
                end
            end

            pipe_slot #(.WIDTH(WIDTH)) u_skid (
                .CLK     (CLK),
                .nRST    (nRST),
                .load_i  (skid_op == SLOT_LOAD_IN),
                .clear_i (skid_op == SLOT_CLEAR),
                .halt_i  (in_halt),
                .data_i  (in_data),
                .valid_o (skid_valid),
                .halt_o  (skid_halt),
                .data_o  (skid_data)
            );

            assign in_ready = !skid_valid && !halted_q;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_halt  = 1'b0;
            assign skid_data  = '0;
            assign in_ready   = (!main_valid || out_ready) && !halted_q;
        end
    endgenerate

    // Halt latches on acceptance of a halt beat; only flush reopens intake.
    always_comb begin
        halted_d = halted_q;
        if (flush) begin
            halted_d = 1'b0;
        end else if (push && in_halt) begin
            halted_d = 1'b1;
        end
    end

    // Sticky halt register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : '0;
    assign out_halt  = main_valid && main_halt;
    assign occupancy = occ_count(main_valid, skid_valid);
    assign halted    = halted_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf.
// Runs a SKID=1 and a SKID=0 instance on shared stimulus.
module tb_pipe_stage_buf;
    import cpu_types_pkg::*;

    localparam int W = 8;

    logic         CLK, nRST, flush;
    logic         in_valid, in_halt, out_ready;
    logic [W-1:0] in_data;

    logic         r1, v1, h1, hd1;
    logic [W-1:0] d1;
    pipe_occ_t    o1;
    logic         r0, v0, h0, hd0;
    logic [W-1:0] d0;
    pipe_occ_t    o0;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_buf #(.WIDTH(W), .SKID(1'b1)) dut1 (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
        .in_halt(in_halt), .out_valid(v1), .out_ready(out_ready),
        .out_data(d1), .out_halt(h1), .occupancy(o1), .halted(hd1)
    );

    pipe_stage_buf #(.WIDTH(W), .SKID(1'b0)) dut0 (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
        .in_halt(in_halt), .out_valid(v0), .out_ready(out_ready),
        .out_data(d0), .out_halt(h0), .occupancy(o0), .halted(hd0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_halt = 0;
        in_data = '0; out_ready = 0;
    endtask

    task automatic test_reset();
        idle();
        nRST = 0;
        #12;
        @(negedge CLK);
        nRST = 1;
        step();
        n_cmp++; if (r1 !== 1'b1) begin n_err++;
            $display("FAIL rst_in_ready1: got %b want 1", r1); end
        n_cmp++; if (r0 !== 1'b1) begin n_err++;
            $display("FAIL rst_in_ready0: got %b want 1", r0); end
        n_cmp++; if (v1 !== 1'b0) begin n_err++;
            $display("FAIL rst_out_valid: got %b want 0", v1); end
        n_cmp++; if (d1 !== 8'h00) begin n_err++;
            $display("FAIL rst_out_data: got %h want 00", d1); end
        n_cmp++; if (o1 !== 2'd0) begin n_err++;
            $display("FAIL rst_occ: got %0d want 0", o1); end
        n_cmp++; if ({h1, hd1} !== 2'b00) begin n_err++;
            $display("FAIL rst_halt: got %b want 00", {h1, hd1}); end
    endtask

    task automatic test_stream();
        logic [W-1:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        out_ready = 1;
        in_valid  = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = beats[i];
            step();
            n_cmp++; if (d1 !== beats[i] || o1 !== 2'd1) begin n_err++;
                $display("FAIL stream1_%0d: got %h/%0d want %h/1",
                         i, d1, o1, beats[i]); end
            n_cmp++; if (d0 !== beats[i] || o0 !== 2'd1) begin n_err++;
                $display("FAIL stream0_%0d: got %h/%0d want %h/1",
                         i, d0, o0, beats[i]); end
        end
        in_valid = 0;
        step();
        n_cmp++; if ({v1, v0} !== 2'b00) begin n_err++;
            $display("FAIL stream_drain: got %b want 00", {v1, v0}); end
        idle();
    endtask

    task automatic test_backpressure();
        idle();
        in_valid = 1; in_data = 8'h0A;
        step();
        in_data = 8'h0B;
        step();
        n_cmp++; if (o1 !== 2'd2 || r1 !== 1'b0) begin n_err++;
            $display("FAIL bp_full: got occ %0d rdy %b want 2/0", o1, r1); end
        n_cmp++; if (d1 !== 8'h0A) begin n_err++;
            $display("FAIL bp_head: got %h want 0a", d1); end
        n_cmp++; if (o0 !== 2'd1 || r0 !== 1'b0 || d0 !== 8'h0A) begin
            n_err++;
            $display("FAIL bp_noskid: got %0d/%b/%h want 1/0/0a",
                     o0, r0, d0); end
        in_valid = 0; out_ready = 1;
        step();
        n_cmp++; if (d1 !== 8'h0B || o1 !== 2'd1 || r1 !== 1'b1) begin
            n_err++;
            $display("FAIL bp_pop1: got %h/%0d/%b want 0b/1/1",
                     d1, o1, r1); end
        n_cmp++; if (v0 !== 1'b0) begin n_err++;
            $display("FAIL bp_pop0: got %b want 0", v0); end
        step();
        n_cmp++; if (v1 !== 1'b0 || o1 !== 2'd0) begin n_err++;
            $display("FAIL bp_pop2: got %b/%0d want 0/0", v1, o1); end
        idle();
    endtask

    task automatic test_halt();
        idle();
        in_valid = 1; in_halt = 1; in_data = 8'h05;
        step();
        n_cmp++; if (hd1 !== 1'b1 || r1 !== 1'b0) begin n_err++;
            $display("FAIL halt_set: got %b/%b want 1/0", hd1, r1); end
        n_cmp++; if (d1 !== 8'h05 || h1 !== 1'b1) begin n_err++;
            $display("FAIL halt_head: got %h/%b want 05/1", d1, h1); end
        in_halt = 0; in_data = 8'h06;
        step();
        step();
        n_cmp++; if (o1 !== 2'd1 || d1 !== 8'h05) begin n_err++;
            $display("FAIL halt_block: got %0d/%h want 1/05", o1, d1); end
        out_ready = 1;
        step();
        n_cmp++; if (v1 !== 1'b0 || d1 !== 8'h00 || hd1 !== 1'b1) begin
            n_err++;
            $display("FAIL halt_drain: got %b/%h/%b want 0/00/1",
                     v1, d1, hd1); end
        n_cmp++; if (hd0 !== 1'b1 || v0 !== 1'b0 || r0 !== 1'b0) begin
            n_err++;
            $display("FAIL halt_noskid: got %b/%b/%b want 1/0/0",
                     hd0, v0, r0); end
        idle();
    endtask

    task automatic test_flush_collision();
        idle();
        flush = 1;
        step();
        flush = 0;
        n_cmp++; if (hd1 !== 1'b0 || r1 !== 1'b1) begin n_err++;
            $display("FAIL flush_unhalt: got %b/%b want 0/1", hd1, r1); end
        in_valid = 1; in_data = 8'h21;
        step();
        in_data = 8'h22; in_halt = 1;
        step();
        n_cmp++; if (o1 !== 2'd2 || hd1 !== 1'b1) begin n_err++;
            $display("FAIL flush_fill: got %0d/%b want 2/1", o1, hd1); end
        flush = 1; in_data = 8'h23; in_halt = 1; out_ready = 1;
        step();
        n_cmp++; if (o1 !== 2'd0 || v1 !== 1'b0 || d1 !== 8'h00) begin
            n_err++;
            $display("FAIL flush_clear: got %0d/%b/%h want 0/0/00",
                     o1, v1, d1); end
        n_cmp++; if (hd1 !== 1'b0 || h1 !== 1'b0 || o0 !== 2'd0) begin
            n_err++;
            $display("FAIL flush_halt: got %b/%b/%0d want 0/0/0",
                     hd1, h1, o0); end
        idle();
    endtask

    task automatic test_replace();
        idle();
        in_valid = 1; in_data = 8'h07;
        step();
        in_data = 8'h08;
        #1;
        n_cmp++; if (r0 !== 1'b0) begin n_err++;
            $display("FAIL repl_blocked: got %b want 0", r0); end
        out_ready = 1;
        #1;
        n_cmp++; if (r0 !== 1'b1) begin n_err++;
            $display("FAIL repl_comb_rdy: got %b want 1", r0); end
        step();
        n_cmp++; if (d0 !== 8'h08 || o0 !== 2'd1) begin n_err++;
            $display("FAIL repl_data0: got %h/%0d want 08/1", d0, o0); end
        n_cmp++; if (d1 !== 8'h08 || o1 !== 2'd1) begin n_err++;
            $display("FAIL repl_data1: got %h/%0d want 08/1", d1, o1); end
        idle();
        out_ready = 1;
        step();
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        in_valid = 1; in_data = 8'h31; in_halt = 1;
        step();
        in_data = 8'h32; in_halt = 0;
        step();
        n_cmp++; if (o1 !== 2'd1 || hd1 !== 1'b1) begin n_err++;
            $display("FAIL arst_pre: got %0d/%b want 1/1", o1, hd1); end
        #2;
        nRST = 0;
        #1;
        n_cmp++; if ({v1, h1, hd1, o1} !== 5'b0 || d1 !== 8'h00) begin
            n_err++;
            $display("FAIL arst_now1: got %b%b%b/%0d/%h want 000/0/00",
                     v1, h1, hd1, o1, d1); end
        n_cmp++; if ({v0, h0, hd0, o0} !== 5'b0 || d0 !== 8'h00) begin
            n_err++;
            $display("FAIL arst_now0: got %b%b%b/%0d/%h want 000/0/00",
                     v0, h0, hd0, o0, d0); end
        idle();
        @(negedge CLK);
        nRST = 1;
        step();
        n_cmp++; if (r1 !== 1'b1 || o1 !== 2'd0) begin n_err++;
            $display("FAIL arst_after: got %b/%0d want 1/0", r1, o1); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_halt();
        test_flush_collision();
        test_replace();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage buffer that replaces the fixed, field-by-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque payload of WIDTH bits and provides a valid/ready handshake, flush-to-bubble, and a sticky halt. It also has an optional second (skid) entry, so the upstream ready is a registered signal rather than a combinational path from downstream. Each stage boundary of the pipeline instantiates one copy and packs its control and data fields into the payload.

## Interface
- WIDTH, 128, payload bits per entry (minimum 1)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- CLK  in  1  rising-edge clock
- nRST  in  1  reset, asynchronous, active-low
- flush  in  1  discard all held entries (branch/jump squash)
- in_valid  in  1  upstream offers a beat
- in_ready  out  1  buffer accepts the beat this cycle
- in_data  in  WIDTH  upstream payload
- in_halt  in  1  offered beat is a halt instruction
- out_valid  out  1  head entry is valid
- out_ready  in  1  downstream consumes the head this cycle (typically the ihit/dhit-qualified advance)
- out_data  out  WIDTH  head payload
- out_halt  out  1  head beat carries halt
- occupancy  out  2  number of valid entries (0..2)
- halted  out  1  a halt beat has been accepted; intake is closed

## Operation
- Push: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready at a rising edge.
- Entries are `main` (head, drives out_*) and `skid` (present only when SKID=1). Each entry holds {valid, halt, data}.
- SKID=1:
  - in_ready = !skid.valid && !halted. This is a registered value only.
  - Push only: the beat goes to main if main is empty or main is being popped; otherwise it goes to skid.
  - Pop with skid valid: skid moves to main. A push in the same cycle then lands in skid.
- SKID=0:
  - in_ready = (!main.valid || out_ready) && !halted.
  - Push with pop in the same cycle replaces main.
- Ordering is strictly FIFO. No beat is ever dropped or duplicated except by flush.
- Halt:
  - Accepting a beat with in_halt=1 sets `halted` on the same edge.
  - halted forces in_ready=0 until flush or reset.
  - The halt beat itself still drains normally with out_halt=1.
- Flush:
  - Next state: all entries invalid, all entry data/halt zero, halted=0.
  - Flush dominates any simultaneous push or pop. A beat pushed in the flush cycle is discarded, and a beat popped in the flush cycle counts as consumed downstream.
- occupancy = main.valid + skid.valid. It is never 2 when SKID=0.
- When out_valid=0, out_data and out_halt are zero. Zeroing the invalid entry yields a NOP bubble.

## Timing
- Reset (async assert, sync release with CLK): every entry is invalid with zero data.
  - out_valid=0, out_data=0, out_halt=0, occupancy=0, halted=0.
  - in_ready=1 after reset, for either SKID value.
- Latency: a beat pushed at edge k is visible on out_* immediately after edge k (1 cycle).
- Throughput: 1 beat/cycle sustained while out_ready=1, for either SKID value.
- SKID=1 backpressure: when out_ready drops, one further beat is absorbed into skid. in_ready falls after that edge.
- Reset mid-operation: all state clears at once, regardless of CLK. No beat survives.
- Boundary cases:
  - Full (occupancy 2) with pop and push together: the count stays 2. This case is unreachable because in_ready=0 while full, so the push is not taken.
  - Empty with pop only: out_ready is ignored.

## Structure
- Add `pipe_occ_t` (logic [1:0]) to cpu_types_pkg.
- Stage-specific payload structs (e.g. the packed MEM/WB field bundle) live in cpu_types_pkg. They are cast to and from the WIDTH-bit payload at the instantiation site.
- One sub-module, `pipe_slot`: a single {valid, halt, data} register with load and clear inputs. It is instantiated once for main and once (generate, SKID=1) for skid.

## Test plan
- Reset release, SKID=1: in_ready=1, out_valid=0, out_data=0, occupancy=0.
- Streaming: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data is 0x11, 0x22, 0x33 on the following three cycles; occupancy stays 1.
- Backpressure, SKID=1:
  - Push 0xA then 0xB with out_ready=0 -> occupancy=2 and in_ready=0 after the second edge.
  - Then raise out_ready -> 0xA pops, then 0xB pops, and in_ready returns to 1 one cycle after the first pop.
- Halt: push 0x5 with in_halt=1, then offer 0x6 -> halted=1 and in_ready=0; 0x6 is never accepted; 0x5 appears with out_halt=1.
- Flush collision: occupancy=2 and the cycle has flush=1 plus in_valid=1 -> next cycle occupancy=0, out_valid=0, out_data=0, halted=0.
- SKID=0 replace: main holds 0x7, out_ready=1 and push 0x8 in the same cycle -> in_ready=1 combinationally and out_data=0x8 next cycle.
- Async reset: assert nRST low mid-stream between clock edges -> all outputs are zero immediately.
